// File: rtl/wb_pkg.sv
// Shared types for the multi-lane writeback stage.
//   WbState : retirement FSM encoding (RUN, DRAIN, HALTED).
//   WbLane  : trace view of one retiring lane at the default register-file
//             geometry (32 registers, 32-bit data).
//   popcount: number of set bits in a lane mask of up to MAX_LANES bits.
package wb_pkg;

  localparam int ADDR_W    = 32;
  localparam int IID_W     = 8;
  localparam int MAX_LANES = 4;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } WbState;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] pc;
    logic [IID_W-1:0]  inst_id;
    logic              rf_wen;
    logic [4:0]        reg_addr;
    logic [31:0]       wdata;
  } WbLane;

  function automatic logic [2:0] popcount(input logic [MAX_LANES-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/multi_lane_wb_stage_order_checker.sv
// In-order retirement checker.
// Tracks the next expected instruction ID and flags (sticky) any cycle in
// which committing lanes are not contiguous from lane 0 or carry IDs other
// than expected, expected+1, ... (modulo IID_W).
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   commit      : per-lane commit mask for this cycle
//   inst_id     : per-lane instruction IDs, lane k at [k*IID_W +: IID_W]
//   order_err   : sticky violation flag
module wb_order_checker
  import wb_pkg::*;
#(
  parameter int LANES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [LANES-1:0]       commit,
  input  logic [LANES*IID_W-1:0] inst_id,
  output logic                   order_err
);

  logic [IID_W-1:0] expected_q, expected_d;
  logic             order_err_q, order_err_d;
  logic             bad;

  always_comb begin
    bad = 1'b0;
    // A mask is contiguous from lane 0 exactly when mask+1 shares no bits with it.
    if ((commit & (commit + LANES'(1))) != '0) begin
      bad = 1'b1;
    end
    for (int k = 0; k < LANES; k++) begin
      if (commit[k] && (inst_id[k*IID_W +: IID_W] != expected_q + IID_W'(k))) begin
        bad = 1'b1;
      end
    end
    expected_d  = expected_q + IID_W'(popcount(MAX_LANES'(commit)));
    order_err_d = order_err_q | ((|commit) & bad);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      expected_q  <= '0;
      order_err_q <= 1'b0;
    end else begin
      expected_q  <= expected_d;
      order_err_q <= order_err_d;
    end
  end

  assign order_err = order_err_q;

endmodule

// File: rtl/multi_lane_wb_stage.sv
// Multi-lane writeback/retire stage.
// Commits up to LANES register writes per cycle (lane 0 oldest, youngest
// lane wins on a same-register conflict), keeps 64-bit cycle and retired
// instruction counters, checks in-order retirement and runs a RUN/DRAIN/HALTED
// FSM that stops retirement on halt_req or on reaching HALT_INST_COUNT.
// Optional macro WB_XZCHECK_EN: a writing lane with X/Z in wdata forces
// HALTED next cycle and prints the offending lane.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   valid/pc/inst_id/rf_wen/reg_addr/wdata : per-lane retire bundle, flattened
//   halt_req         : level halt request
//   regfile          : architectural registers, reg r at [r*DATA_W +: DATA_W]
//   clock_count      : cycles since reset
//   inst_count       : instructions retired since reset
//   state            : WbState encoding
//   halted           : high in HALTED
//   order_err        : sticky in-order violation flag
module multi_lane_wb_stage
  import wb_pkg::*;
#(
  parameter int               LANES           = 2,
  parameter int               DATA_W          = 32,
  parameter int               NREGS           = 32,
  parameter logic [DATA_W-1:0] RESET_VAL      = '1,
  parameter logic [63:0]      HALT_INST_COUNT = 64'd0,
  parameter int               DRAIN_CYCLES    = 4,
  localparam int              RAW             = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [LANES-1:0]        valid,
  input  logic [LANES*ADDR_W-1:0] pc,
  input  logic [LANES*IID_W-1:0]  inst_id,
  input  logic [LANES-1:0]        rf_wen,
  input  logic [LANES*RAW-1:0]    reg_addr,
  input  logic [LANES*DATA_W-1:0] wdata,
  input  logic                    halt_req,
  output logic [NREGS*DATA_W-1:0] regfile,
  output logic [63:0]             clock_count,
  output logic [63:0]             inst_count,
  output logic [1:0]              state,
  output logic                    halted,
  output logic                    order_err
);

  localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  WbState            state_q, state_d;
  logic [DCW-1:0]    drain_q, drain_d;
  logic [DATA_W-1:0] regfile_q [NREGS];
  logic [DATA_W-1:0] regfile_d [NREGS];
  logic [63:0]       clock_count_q, clock_count_d;
  logic [63:0]       inst_count_q, inst_count_d;
  logic [LANES-1:0]  commit;
  logic              xz_hit;

  assign commit = valid & {LANES{state_q != HALTED}};

  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      regfile_d[r] = regfile_q[r];
    end
    // Ascending lane order lets the youngest lane overwrite older ones.
    for (int k = 0; k < LANES; k++) begin
      if (commit[k] && rf_wen[k] && (reg_addr[k*RAW +: RAW] != '0)) begin
        regfile_d[reg_addr[k*RAW +: RAW]] = wdata[k*DATA_W +: DATA_W];
      end
    end
    regfile_d[0] = '0;
  end

  always_comb begin
    clock_count_d = clock_count_q + 64'd1;
    inst_count_d  = inst_count_q + 64'(popcount(MAX_LANES'(commit)));
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      RUN: begin
        if (halt_req || ((HALT_INST_COUNT != 64'd0) && (inst_count_d >= HALT_INST_COUNT))) begin
          state_d = DRAIN;
          drain_d = DCW'(DRAIN_CYCLES - 1);
        end
      end
      DRAIN: begin
        if (drain_q == '0) begin
          state_d = HALTED;
        end else begin
          drain_d = drain_q - DCW'(1);
        end
      end
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
    if (xz_hit) begin
      state_d = HALTED;
    end
  end

`ifdef WB_XZCHECK_EN
  always_comb begin
    xz_hit = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      if (commit[k] && rf_wen[k] && (reg_addr[k*RAW +: RAW] != '0) &&
          $isunknown(wdata[k*DATA_W +: DATA_W])) begin
        xz_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < LANES; k++) begin
        if (commit[k] && rf_wen[k] && (reg_addr[k*RAW +: RAW] != '0) &&
            $isunknown(wdata[k*DATA_W +: DATA_W])) begin
          $display("wb xz: lane %0d pc %h reg %0d wdata %h", k, pc[k*ADDR_W +: ADDR_W],
                   reg_addr[k*RAW +: RAW], wdata[k*DATA_W +: DATA_W]);
        end
      end
    end
  end
`else
  logic unused_pc;
  assign xz_hit    = 1'b0;
  assign unused_pc = ^pc;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      drain_q       <= '0;
      clock_count_q <= '0;
      inst_count_q  <= '0;
      for (int r = 0; r < NREGS; r++) begin
        regfile_q[r] <= (r == 0) ? '0 : RESET_VAL;
      end
    end else begin
      state_q       <= state_d;
      drain_q       <= drain_d;
      clock_count_q <= clock_count_d;
      inst_count_q  <= inst_count_d;
      for (int r = 0; r < NREGS; r++) begin
        regfile_q[r] <= regfile_d[r];
      end
    end
  end

  wb_order_checker #(
    .LANES(LANES)
  ) u_order_checker (
    .clk      (clk),
    .reset    (reset),
    .commit   (commit),
    .inst_id  (inst_id),
    .order_err(order_err)
  );

  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      regfile[r*DATA_W +: DATA_W] = regfile_q[r];
    end
  end

  assign clock_count = clock_count_q;
  assign inst_count  = inst_count_q;
  assign state       = state_q;
  assign halted      = (state_q == HALTED);

endmodule

// File: tb/tb_multi_lane_wb_stage.sv
// Bench for multi_lane_wb_stage (LANES=2, HALT_INST_COUNT=5, DRAIN_CYCLES=2).
// A reference model predicts each cycle's outcome when stimulus is driven and
// queues it; the entry is popped and compared one cycle later.
module tb_multi_lane_wb_stage;
  import wb_pkg::*;

  localparam int LANES = 2;
  localparam int DW    = 32;
  localparam int NR    = 32;
  localparam int RAW   = 5;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic [LANES-1:0]        valid = '0;
  logic [LANES*ADDR_W-1:0] pc = '0;
  logic [LANES*IID_W-1:0]  inst_id = '0;
  logic [LANES-1:0]        rf_wen = '0;
  logic [LANES*RAW-1:0]    reg_addr = '0;
  logic [LANES*DW-1:0]     wdata = '0;
  logic                    halt_req = 1'b0;
  logic [NR*DW-1:0]        regfile;
  logic [63:0]             clock_count, inst_count;
  logic [1:0]              state;
  logic                    halted, order_err;

  always #5 clk = ~clk;

  multi_lane_wb_stage #(
    .LANES(LANES), .DATA_W(DW), .NREGS(NR), .RESET_VAL(32'hFFFF_FFFF),
    .HALT_INST_COUNT(64'd5), .DRAIN_CYCLES(2)
  ) dut (
    .clk(clk), .reset(reset), .valid(valid), .pc(pc), .inst_id(inst_id),
    .rf_wen(rf_wen), .reg_addr(reg_addr), .wdata(wdata), .halt_req(halt_req),
    .regfile(regfile), .clock_count(clock_count), .inst_count(inst_count),
    .state(state), .halted(halted), .order_err(order_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          ridx;
    logic [31:0] rval;
    logic [63:0] icnt;
    logic [63:0] ccnt;
    logic        err;
    logic [1:0]  st;
  } exp_t;
  exp_t sb[$];

  logic [31:0] m_rf [NR];
  logic [63:0] m_icnt, m_ccnt;
  logic [7:0]  m_exp;
  logic        m_err;
  logic [1:0]  m_st;
  int          m_drain;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] rf(input int i);
    return regfile[i*DW +: DW];
  endfunction

  task automatic do_reset();
    reset = 1'b1; valid = '0; rf_wen = '0; halt_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int r = 0; r < NR; r++) m_rf[r] = (r == 0) ? 32'h0 : 32'hFFFF_FFFF;
    m_icnt = 0; m_ccnt = 0; m_exp = 0; m_err = 0; m_st = 2'd0; m_drain = 0;
    sb.delete();
    chk("rst_x0", rf(0), 32'h0);
    chk("rst_x5", rf(5), 32'hFFFF_FFFF);
    chk("rst_inst", inst_count, 64'd0);
    chk("rst_clk", clock_count, 64'd0);
    chk("rst_state", state, 2'd0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_err", order_err, 1'b0);
  endtask

  task automatic cycle(input logic [1:0] v, input logic [7:0] id0, input logic [7:0] id1,
                       input logic [1:0] wen, input logic [4:0] a0, input logic [4:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1, input logic hreq);
    logic [1:0]  c;
    int          n;
    logic [63:0] nxt;
    exp_t        e;
    exp_t        got;
    valid = v; inst_id = {id1, id0}; rf_wen = wen; reg_addr = {a1, a0};
    wdata = {d1, d0}; pc = {32'h0000_1004, 32'h0000_1000}; halt_req = hreq;
    // Reference model for the edge that follows.
    c = (m_st == 2'd2) ? 2'b00 : v;
    n = int'(c[0]) + int'(c[1]);
    if (c != 2'b00) begin
      if (c == 2'b10) m_err = 1'b1;
      if (c[0] && (id0 != m_exp)) m_err = 1'b1;
      if (c[1] && (id1 != m_exp + 8'd1)) m_err = 1'b1;
      m_exp = m_exp + 8'(n);
    end
    if (c[0] && wen[0] && (a0 != 0)) m_rf[a0] = d0;
    if (c[1] && wen[1] && (a1 != 0)) m_rf[a1] = d1;
    nxt = m_icnt + 64'(n);
    case (m_st)
      2'd0: if (hreq || (nxt >= 64'd5)) begin m_st = 2'd1; m_drain = 1; end
      2'd1: if (m_drain == 0) m_st = 2'd2; else m_drain--;
      default: m_st = 2'd2;
    endcase
    m_icnt = nxt;
    m_ccnt = m_ccnt + 64'd1;
    e.ridx = v[1] ? int'(a1) : int'(a0);
    e.rval = m_rf[e.ridx];
    e.icnt = m_icnt; e.ccnt = m_ccnt; e.err = m_err; e.st = m_st;
    sb.push_back(e);
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 64'd1, 64'd0);
    end else begin
      got = sb.pop_front();
      chk("sb_reg", rf(got.ridx), got.rval);
      chk("sb_inst", inst_count, got.icnt);
      chk("sb_clk", clock_count, got.ccnt);
      chk("sb_err", order_err, got.err);
      chk("sb_state", state, got.st);
      chk("sb_halted", halted, got.st == 2'd2);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    do_reset();

    // Same-register conflict: youngest lane wins.
    cycle(2'b11, 8'd0, 8'd1, 2'b11, 5'd3, 5'd3, 32'h11, 32'h22, 1'b0);
    chk("conf_x3", rf(3), 32'h22);
    chk("conf_inst", inst_count, 64'd2);
    chk("conf_err", order_err, 1'b0);

    // x0 is never written.
    do_reset();
    cycle(2'b01, 8'd0, 8'd0, 2'b01, 5'd0, 5'd0, 32'h5, 32'h0, 1'b0);
    chk("x0_val", rf(0), 32'h0);
    chk("x0_inst", inst_count, 64'd1);

    // ID skip sets order_err.
    do_reset();
    cycle(2'b11, 8'd0, 8'd1, 2'b11, 5'd1, 5'd2, 32'hA1, 32'hA2, 1'b0);
    chk("ord_ok", order_err, 1'b0);
    cycle(2'b11, 8'd3, 8'd4, 2'b11, 5'd1, 5'd2, 32'hB1, 32'hB2, 1'b0);
    chk("ord_skip", order_err, 1'b1);
    chk("ord_wr", rf(2), 32'hB2);

    // Lane gap sets order_err.
    do_reset();
    cycle(2'b10, 8'd0, 8'd1, 2'b10, 5'd0, 5'd6, 32'h0, 32'h66, 1'b0);
    chk("gap_err", order_err, 1'b1);
    chk("gap_inst", inst_count, 64'd1);

    // Instruction-count limit: DRAIN after crossing 5, HALTED two cycles later.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      cycle(2'b11, 8'(2*i), 8'(2*i+1), 2'b11, 5'd7, 5'd8, 32'h700 + i, 32'h800 + i, 1'b0);
      if (i == 2) begin
        chk("lim_drain", state, 2'd1);
        chk("lim_cnt6", inst_count, 64'd6);
      end
      if (i == 4) begin
        chk("lim_halt", state, 2'd2);
        chk("lim_cnt10", inst_count, 64'd10);
      end
    end
    chk("halt_frozen", inst_count, 64'd10);
    chk("halt_clk", clock_count, 64'd7);
    chk("halt_nowr", rf(7), 32'h704);
    chk("halt_flag", halted, 1'b1);

    // halt_req pulse, then reset during DRAIN.
    do_reset();
    cycle(2'b00, 8'd0, 8'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1);
    chk("hreq_drain", state, 2'd1);
    cycle(2'b01, 8'd0, 8'd0, 2'b01, 5'd9, 5'd0, 32'hABCD, 32'h0, 1'b0);
    chk("drain_stay", state, 2'd1);
    chk("drain_wr", rf(9), 32'hABCD);
    do_reset();
    chk("rst_x9", rf(9), 32'hFFFF_FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_lane_wb_stage.md
Name: multi_lane_wb_stage

Overview:
- Parametrised N-lane writeback/retire stage at the end of the pipeline; successor to the single-lane writeback stage.
- Commits up to LANES register writes per cycle into the architectural register file and keeps 64-bit cycle and retired-instruction counters.
- Checks in-order retirement by instruction ID.
- Run/drain/halt FSM stops simulation-visible retirement on request or when an instruction-count limit is reached.

Parameters:
- LANES, 2, retire lanes per cycle; lane 0 is oldest; range 1..4.
- DATA_W, 32, register data width.
- NREGS, 32, architectural registers; reg 0 hardwired to zero.
- RESET_VAL, all-ones (DATA_W bits), reset value of regs 1..NREGS-1.
- HALT_INST_COUNT, 0, retired-count limit that triggers drain; 0 disables the limit.
- DRAIN_CYCLES, 4, cycles spent in DRAIN before entering HALTED; must be >= 1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- valid  in  LANES  per-lane retire valid.
- pc  in  LANES x Addr  per-lane PC (debug/trace).
- inst_id  in  LANES x IId  per-lane instruction ID.
- rf_wen  in  LANES  per-lane register write enable.
- reg_addr  in  LANES x log2(NREGS)  per-lane destination register.
- wdata  in  LANES x DATA_W  per-lane write data.
- halt_req  in  1  external halt request (level).
- regfile  out  NREGS x DATA_W  architectural register file.
- clock_count  out  64  cycles since reset.
- inst_count  out  64  instructions retired since reset.
- state  out  2  WbState encoding.
- halted  out  1  high in HALTED.
- order_err  out  1  sticky in-order violation flag.

Behaviour:
- Reset (synchronous): regfile[0]=0, others RESET_VAL; both counters 0; state=RUN; halted=0; order_err=0; expected-ID register=0.
- Lane commit: a lane commits when valid[k], state != HALTED and reset is low.
- Write: lane k writes when it commits, rf_wen[k]=1 and reg_addr[k] != 0. The write is visible on regfile in the next cycle (1-cycle latency).
- Same-address conflict in one cycle: highest-numbered (youngest) lane wins.
- Reg 0: never written; always reads 0.
- clock_count: +1 every non-reset cycle, including HALTED.
- inst_count: += popcount of committing lanes; 64-bit wrap-around is allowed.
- Order check (committing cycles only):
  - Valid lanes must be contiguous from lane 0.
  - Lane k's inst_id must equal expected+k, modulo IId width; expected then advances by the number committed.
  - Any mismatch or gap sets order_err (sticky until reset). Writes still occur.
- FSM:
  - RUN -> DRAIN when halt_req=1, or when HALT_INST_COUNT != 0 and the next-cycle inst_count >= HALT_INST_COUNT. All lanes valid in the crossing cycle still commit, so inst_count may overshoot the limit by up to LANES-1.
  - DRAIN: lanes still commit; a down-counter starts at DRAIN_CYCLES-1. At 0 -> HALTED. halt_req deasserting in DRAIN does not return to RUN.
  - HALTED: absorbing; no writes, inst_count frozen, halted=1. Only reset exits.
- Reset asserted in any state, including mid-DRAIN, overrides everything in that cycle and the FSM returns to RUN.

Optional Feature:
- Macro WB_XZCHECK_EN.
- Defined: any writing lane whose wdata contains an X/Z bit forces the next state to HALTED (skipping DRAIN). The offending write still occurs. $display prints lane, pc, reg_addr, wdata.
- Undefined: no check; the logic is absent from synthesis.

Decomposition:
- Package wb_pkg holds:
  - WbState enum {RUN, DRAIN, HALTED};
  - WbLane struct {valid, pc, inst_id, rf_wen, reg_addr, wdata};
  - the popcount function.
- Sub-module wb_order_checker: owns the expected-ID register and the contiguity check; outputs order_err.

Test Plan:
- Reset, then read regs -> regfile[0]=0, regfile[5]=32'hFFFF_FFFF, inst_count=0, state=RUN.
- LANES=2; lane0 writes x3<=0x11, lane1 writes x3<=0x22, ids 0,1 -> next cycle x3=0x22, inst_count=2, order_err=0.
- Lane0 writes x0<=0x5 -> x0 stays 0; inst_count=1.
- Ids 0,1 then 3,4 -> order_err=1 after the second cycle; valid=2'b10 -> order_err=1.
- HALT_INST_COUNT=5, DRAIN_CYCLES=2, both lanes valid each cycle -> DRAIN after count crosses 5 (reaches 6), HALTED 2 cycles later, inst_count frozen, clock_count still increments.
- halt_req pulse, reset asserted during DRAIN -> next cycle state=RUN, counters 0, regs at reset values.
